// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with byte FIFO.
module uart_tx #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               data,
    input  logic                     we,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     tx
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = $clog2(DIV);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push, pop, baud_done;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign busy      = (state_q != IDLE) | ~empty;
    assign tx        = tx_q;
    assign push      = we & ~full;
    assign baud_done = (baud_q == '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more bytes are queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_RELOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the state; tx_q registers it one cycle later.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx (DIV=10/DEPTH=4 instance and default instance).
module tb_uart_tx;
    localparam int DIV_A = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       we_a, we_b;
    logic       full_a, empty_a, busy_a, tx_a;
    logic [2:0] count_a;
    logic       full_b, empty_b, busy_b, tx_b;
    logic [4:0] count_b;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_HZ(1000), .BAUD(100), .DEPTH(4)) dut_a (
        .clock(clk), .reset(rst), .data(data_a), .we(we_a),
        .full(full_a), .empty(empty_a), .count(count_a), .busy(busy_a), .tx(tx_a)
    );

    uart_tx dut_b (
        .clock(clk), .reset(rst), .data(data_b), .we(we_b),
        .full(full_b), .empty(empty_b), .count(count_b), .busy(busy_b), .tx(tx_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for a start bit on tx_a and samples each bit at its centre.
    task automatic rx_frame(output logic [7:0] b, output bit ok, output int t0);
        int w = 0;
        ok = 1'b1;
        b  = '0;
        t0 = 0;
        while (tx_a !== 1'b0 && w < 1000) begin
            step(1);
            w++;
        end
        if (w >= 1000) begin
            ok = 1'b0;
            return;
        end
        t0 = cyc;
        step(DIV_A / 2);
        if (tx_a !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(DIV_A);
            b[i] = tx_a;
        end
        step(DIV_A);
        if (tx_a !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; we_a = 1'b0; we_b = 1'b0; data_a = '0; data_b = '0;
        step(2);
        vecs++;
        if ({tx_a, full_a, empty_a, count_a, busy_a} !== {1'b1, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_a: got tx/full/empty/count/busy=%b want 1_0_1_000_0",
                     {tx_a, full_a, empty_a, count_a, busy_a});
        end
        vecs++;
        if ({tx_b, full_b, empty_b, count_b, busy_b} !== {1'b1, 1'b0, 1'b1, 5'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_b: got tx/full/empty/count/busy=%b want 1_0_1_00000_0",
                     {tx_b, full_b, empty_b, count_b, busy_b});
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_single;
        logic [7:0] v = 8'h55;
        logic       exp;
        bit         bad;
        data_a = v; we_a = 1'b1;
        step(1);
        we_a = 1'b0; data_a = 8'hEE;
        vecs++;
        if (empty_a !== 1'b0 || tx_a !== 1'b1) begin
            errs++;
            $display("FAIL single_e0: got empty=%b tx=%b want empty=0 tx=1", empty_a, tx_a);
        end
        step(1);
        vecs++;
        if (tx_a !== 1'b1) begin
            errs++;
            $display("FAIL single_e1_tx: got %b want 1", tx_a);
        end
        step(1);
        for (int b = 0; b < 10; b++) begin
            exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : v[b-1];
            bad = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (b != 0 || c != 0) step(1);
                if (tx_a !== exp) bad = 1'b1;
            end
            vecs++;
            if (bad) begin
                errs++;
                $display("FAIL single_bit%0d: got tx=%b at end want %b for 10 clocks", b, tx_a, exp);
            end
        end
        vecs++;
        if (busy_a !== 1'b0 || empty_a !== 1'b1) begin
            errs++;
            $display("FAIL single_done: got busy=%b empty=%b want busy=0 empty=1", busy_a, empty_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b0, b1;
        bit         ok0, ok1;
        int         t0, t1;
        step(5);
        data_a = 8'hA3; we_a = 1'b1;
        step(1);
        data_a = 8'h0F;
        step(1);
        we_a = 1'b0;
        rx_frame(b0, ok0, t0);
        rx_frame(b1, ok1, t1);
        vecs++;
        if (!ok0 || b0 !== 8'hA3) begin
            errs++;
            $display("FAIL b2b_first: got %h ok=%0d want a3 ok=1", b0, ok0);
        end
        vecs++;
        if (!ok1 || b1 !== 8'h0F) begin
            errs++;
            $display("FAIL b2b_second: got %h ok=%0d want 0f ok=1", b1, ok1);
        end
        vecs++;
        if (t1 - t0 != 100) begin
            errs++;
            $display("FAIL b2b_spacing: got %0d clocks want 100", t1 - t0);
        end
        step(20);
    endtask

    task automatic test_overflow;
        logic [7:0] got [5];
        bit         ok  [5];
        int         t;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    data_a = 8'h10 + 8'(i); we_a = 1'b1;
                    step(1);
                    if (i == 3) begin
                        vecs++;
                        if (full_a !== 1'b0 || count_a !== 3'd3) begin
                            errs++;
                            $display("FAIL ovf_w4: got full=%b count=%0d want 0/3", full_a, count_a);
                        end
                    end
                    if (i == 4) begin
                        vecs++;
                        if (full_a !== 1'b1) begin
                            errs++;
                            $display("FAIL ovf_full: got %b want 1", full_a);
                        end
                    end
                    if (i == 5) begin
                        vecs++;
                        if (count_a !== 3'd4) begin
                            errs++;
                            $display("FAIL ovf_drop_count: got %0d want 4", count_a);
                        end
                    end
                end
                we_a = 1'b0;
            end
            begin
                for (int k = 0; k < 5; k++) rx_frame(got[k], ok[k], t);
            end
        join
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (!ok[k] || got[k] !== 8'h10 + 8'(k)) begin
                errs++;
                $display("FAIL ovf_byte%0d: got %h ok=%0d want %h", k, got[k], ok[k], 8'h10 + 8'(k));
            end
        end
        step(10);
        vecs++;
        if (count_a !== 3'd0 || empty_a !== 1'b1 || busy_a !== 1'b0) begin
            errs++;
            $display("FAIL ovf_drain: got count=%0d empty=%b busy=%b want 0/1/0", count_a, empty_a, busy_a);
        end
        begin
            int lows = 0;
            for (int c = 0; c < 150; c++) begin
                step(1);
                if (tx_a !== 1'b1) lows++;
            end
            vecs++;
            if (lows != 0) begin
                errs++;
                $display("FAIL ovf_no_sixth: got %0d non-idle clocks want 0", lows);
            end
        end
    endtask

    task automatic test_wrap;
        localparam int N = 13;
        logic [7:0] got [N];
        bit         ok  [N];
        int         t;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    int w = 0;
                    while (count_a >= 3'd2 && w < 2000) begin
                        step(1);
                        w++;
                    end
                    data_a = 8'h40 + 8'(i); we_a = 1'b1;
                    step(1);
                    we_a = 1'b0;
                end
            end
            begin
                for (int k = 0; k < N; k++) rx_frame(got[k], ok[k], t);
            end
        join
        for (int k = 0; k < N; k++) begin
            vecs++;
            if (!ok[k] || got[k] !== 8'h40 + 8'(k)) begin
                errs++;
                $display("FAIL wrap_byte%0d: got %h ok=%0d want %h", k, got[k], ok[k], 8'h40 + 8'(k));
            end
        end
        step(20);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        bit         ok;
        int         t, lows;
        data_a = 8'hFF; we_a = 1'b1;
        step(1);
        data_a = 8'h77;
        step(1);
        data_a = 8'h88;
        step(1);
        we_a = 1'b0;
        step(43);
        vecs++;
        if (count_a !== 3'd2 || busy_a !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_pre: got count=%0d busy=%b want 2/1", count_a, busy_a);
        end
        rst = 1'b1;
        step(1);
        vecs++;
        if (tx_a !== 1'b1 || count_a !== 3'd0 || empty_a !== 1'b1 || busy_a !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_edge: got tx=%b count=%0d empty=%b busy=%b want 1/0/1/0",
                     tx_a, count_a, empty_a, busy_a);
        end
        rst = 1'b0;
        lows = 0;
        for (int c = 0; c < 300; c++) begin
            step(1);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        vecs++;
        if (lows != 0) begin
            errs++;
            $display("FAIL rstmid_quiet: got %0d active clocks want 0", lows);
        end
        data_a = 8'h5A; we_a = 1'b1;
        step(1);
        we_a = 1'b0;
        rx_frame(b, ok, t);
        vecs++;
        if (!ok || b !== 8'h5A) begin
            errs++;
            $display("FAIL rstmid_recover: got %h ok=%0d want 5a", b, ok);
        end
        step(20);
    endtask

    task automatic test_default_div;
        int w = 0, lo = 0, hi = 0;
        data_b = 8'h00; we_b = 1'b1;
        step(2);
        we_b = 1'b0;
        while (tx_b !== 1'b0 && w < 20) begin
            step(1);
            w++;
        end
        while (tx_b === 1'b0 && lo < 5000) begin
            lo++;
            step(1);
        end
        while (tx_b === 1'b1 && hi < 5000) begin
            hi++;
            step(1);
        end
        vecs++;
        if (lo != 1953) begin
            errs++;
            $display("FAIL default_low: got %0d clocks want 1953", lo);
        end
        vecs++;
        if (hi != 217) begin
            errs++;
            $display("FAIL default_stop: got %0d clocks want 217", hi);
        end
        w = 0;
        while (busy_b !== 1'b0 && w < 5000) begin
            step(1);
            w++;
        end
        vecs++;
        if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
            errs++;
            $display("FAIL default_done: got busy=%b tx=%b want 0/1", busy_b, tx_b);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
        $fatal(1);
    end

    initial begin
        step(1);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_midframe();
        test_default_div();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial 8N1 transmitter that drives the board TX pin. It is the sending counterpart to the RX input line.
The core, or a port-mapped I/O decoder, pushes bytes into a small FIFO. The block serialises them LSB-first at a fixed baud rate derived from the 25 MHz system clock.
It sits beside the core on clock_25, and its `tx` output goes straight to the top-level TX pin.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
DEPTH, 16, FIFO depth in bytes; power of two, minimum 2

Ports:
clock  input  1  system clock (clock_25)
reset  input  1  synchronous reset, active-high
data  input  8  byte to enqueue
we  input  1  write strobe; one byte is enqueued per cycle in which it is high
full  output  1  FIFO holds DEPTH bytes
empty  output  1  FIFO holds 0 bytes
count  output  $clog2(DEPTH)+1  number of bytes currently held in the FIFO
busy  output  1  high while a frame is on the line or the FIFO is non-empty
tx  output  1  serial line; idle high

Behaviour:
- One clock domain. Reset is synchronous and active-high; it is sampled on the rising edge of clock.
- Reset values: tx=1, full=0, empty=1, count=0, busy=0. FIFO pointers are zeroed, the FSM is IDLE and the bit counters are zeroed.
- Reset mid-frame: the frame is aborted and tx=1 from the reset edge onward. FIFO contents are discarded.
- Divisor: DIV = (CLK_HZ + BAUD/2) / BAUD, integer. Default DIV = 217.
  - The baud counter is $clog2(DIV) bits wide, counts DIV-1 down to 0, and reloads.
  - Every line bit lasts exactly DIV clocks.
- FIFO:
  - Circular buffer with DEPTH entries, read and write pointers of $clog2(DEPTH) bits that wrap naturally, and a separate count register.
  - A write is accepted when we=1 and full=0, where full is the registered value from the current cycle.
  - A write while full is silently dropped; contents and count are unchanged.
  - A simultaneous accepted write and pop leaves count unchanged.
  - A write while full in the same cycle as a pop is still dropped.
  - full and empty are derived from registered count, so they update one cycle after the write or pop edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0, pop the head byte into the shift register, load the baud counter with DIV-1, set tx=0 and go to START.
  - START: when the baud counter reaches 0, drive tx=shift[0], set the bit index to 0 and go to DATA.
  - DATA: at each baud expiry, shift right and increment the bit index. After bit 7 has lasted DIV clocks, drive tx=1 and go to STOP.
  - STOP: after DIV clocks, if empty=0, pop the next byte and set tx=0 in the same cycle, going back to START with no idle gap. Otherwise go to IDLE.
- Latency: a byte written into an empty FIFO while IDLE is sampled at edge E. Then empty=0 after E, and tx falls at edge E+2.
- Frame length: exactly 10*DIV clocks from the start-bit falling edge to the next possible start-bit falling edge.
- tx is registered and glitch-free; it changes only on FSM or baud-expiry edges.
- busy = (state != IDLE) | ~empty. It is low only when the line is idle and nothing is queued.
- data is captured on the write edge; later changes to data do not affect queued bytes.

Test Plan:
1. Single byte, with CLK_HZ=1000, BAUD=100 (DIV=10): write 0x55 at edge E.
   - tx=1 until E+2.
   - Line sequence is 0,1,0,1,0,1,0,1,0,1; each level lasts 10 clocks.
   - Stop bit is high for 10 clocks, then busy=0 and empty=1.
2. Back-to-back: write 0xA3 and 0x0F on consecutive cycles.
   - Frames decode as 0xA3 then 0x0F, LSB-first.
   - The second start bit falls exactly 100 clocks after the first.
   - No extra idle cycles occur between the frames.
3. Overflow, DEPTH=4: with the line idle, write 6 bytes 0x10–0x15 on consecutive cycles.
   - The first byte is popped at edge E+1, so full asserts after the 5th write.
   - The 6th byte is dropped.
   - The line carries 0x10–0x14 in that order, and count returns to 0.
4. Pointer wrap: push and transmit 3*DEPTH+1 bytes with an incrementing pattern, keeping count below DEPTH.
   - All bytes appear on the line in order with no corruption across the pointer wrap.
5. Reset mid-frame: assert reset during bit 3 of 0xFF with 2 bytes queued.
   - tx=1 from the reset edge and count=0.
   - After release, no frame is sent until a new write arrives.
6. Default parameters (25 MHz / 115200): write 0x00.
   - Start bit plus data bits give one low period of exactly 9*217 = 1953 clocks.
   - The stop bit then lasts 217 clocks.
